// File: rtl/data_memory_stage.sv
// MEM-stage data memory for the pipelined MIPS core: one access per request after
// WAIT_CYCLES wait states, with a pipeline stall while the access is in progress.
module data_memory_stage #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          MEMORY_DEPTH = 256,
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
  parameter int          WAIT_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  IN_MemRead,
  input  logic                  IN_MemWrite,
  input  logic [31:0]           IN_Address,
  input  logic [DATA_WIDTH-1:0] IN_WriteData,
  output logic [DATA_WIDTH-1:0] OUT_ReadData,
  output logic                  OUT_Stall,
  output logic                  OUT_Valid,
  output logic                  OUT_AddrError
);

  localparam int IDX_W = $clog2(MEMORY_DEPTH);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [32:0] RANGE = 33'(MEMORY_DEPTH) << 2;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  write_q, write_d;
  logic [IDX_W-1:0]      index_q, index_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  error_d;
  logic                  access;

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  // Unsigned offset: addresses below BASE_ADDR wrap to huge values and fail the range test.
  logic [31:0] offset;
  logic        req;
  logic        legal;

  assign offset = IN_Address - BASE_ADDR;
  assign req    = IN_MemRead | IN_MemWrite;
  assign legal  = (IN_Address[1:0] == 2'b00) && ({1'b0, offset} < RANGE);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    write_d   = write_q;
    index_d   = index_q;
    data_d    = data_q;
    error_d   = 1'b0;
    access    = 1'b0;
    OUT_Stall = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (legal) begin
            write_d   = IN_MemWrite;  // read+write together behaves as a store
            index_d   = offset[IDX_W+1:2];
            data_d    = IN_WriteData;
            count_d   = CNT_W'(WAIT_CYCLES - 1);
            state_d   = BUSY;
            OUT_Stall = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      BUSY: begin
        OUT_Stall = 1'b1;
        if (count_q != '0) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          access  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign OUT_Valid = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      write_q       <= 1'b0;
      index_q       <= '0;
      data_q        <= '0;
      OUT_AddrError <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      write_q       <= write_d;
      index_q       <= index_d;
      data_q        <= data_d;
      OUT_AddrError <= error_d;
    end
  end

  // RAM contents survive reset; a store landing on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (access && write_q && !reset) begin
      mem[index_q] <= data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      OUT_ReadData <= '0;
    end else if (access && !write_q) begin
      OUT_ReadData <= mem[index_q];
    end
  end

endmodule
